// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// MEM stage of the 5-stage RV32I core. Takes the EX bundle, performs loads and
// stores over a byte-wide RAM port shared with instruction fetch, and produces
// the registered writeback bundle for the MEM/WB register.
//
// Multi-byte accesses are serialised one byte per granted cycle,
// little-endian. stall_req_o freezes IF/ID/EX until the access completes.
//
// Optional feature:
//   MEM_MISALIGN_TRAP_EN - when defined, misaligned LH/LHU/SH/LW/SW do no
//   RAM access. They complete the next cycle with misalign_o=1 and rd_en_o=0.
//   When undefined, misaligned accesses run byte-serially and misalign_o is
//   tied 0.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   valid_i         EX bundle valid
//   mem_op_i        0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW
//   addr_i          effective address
//   wdata_i         store data
//   rd_addr_i       destination register
//   rd_en_i         destination write enable
//   rd_data_i       ALU result for non-memory ops
//   ram_grant_i     RAM port granted to MEM this cycle
//   ram_din_i       RAM read byte, valid one cycle after address issue
//   ram_addr_o      RAM byte address
//   ram_wr_o        RAM write strobe
//   ram_dout_o      RAM write byte
//   stall_req_o     freeze upstream stages
//   valid_o         writeback valid pulse
//   rd_addr_o       writeback register
//   rd_en_o         writeback enable
//   rd_data_o       writeback data
//   misalign_o      misaligned access flag
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [3:0]        mem_op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              rd_en_i,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic              ram_grant_i,
  input  logic [7:0]        ram_din_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_wr_o,
  output logic [7:0]        ram_dout_o,
  output logic              stall_req_o,
  output logic              valid_o,
  output logic [4:0]        rd_addr_o,
  output logic              rd_en_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              misalign_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Access size in bytes; 0 marks a non-memory op.
  function automatic logic [2:0] op_bytes(input logic [3:0] op);
    case (op)
      4'd1, 4'd4, 4'd6: op_bytes = 3'd1;
      4'd2, 4'd5, 4'd7: op_bytes = 3'd2;
      4'd3, 4'd8:       op_bytes = 3'd4;
      default:          op_bytes = 3'd0;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    case (op)
      4'd6, 4'd7, 4'd8: op_is_store = 1'b1;
      default:          op_is_store = 1'b0;
    endcase
  endfunction

  // Sign/zero extension of the assembled load word.
  function automatic logic [DATA_W-1:0] load_ext(input logic [3:0] op,
                                                 input logic [DATA_W-1:0] w);
    case (op)
      4'd1:    load_ext = {{(DATA_W-8){w[7]}}, w[7:0]};
      4'd2:    load_ext = {{(DATA_W-16){w[15]}}, w[15:0]};
      4'd4:    load_ext = {{(DATA_W-8){1'b0}}, w[7:0]};
      4'd5:    load_ext = {{(DATA_W-16){1'b0}}, w[15:0]};
      default: load_ext = w;
    endcase
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] a);
    case (op)
      4'd2, 4'd5, 4'd7: op_misaligned = a[0];
      4'd3, 4'd8:       op_misaligned = (a != 2'd0);
      default:          op_misaligned = 1'b0;
    endcase
  endfunction
`endif

  logic [1:0]        state_r;
  logic [3:0]        op_r;
  logic [ADDR_W-1:0] base_r;
  logic [DATA_W-1:0] wdata_r;
  logic [4:0]        rd_addr_r;
  logic              rd_en_r;
  logic [2:0]        k_r;
  logic              issued_r;
  logic [1:0]        lane_r;
  logic [DATA_W-1:0] asm_r;

  logic              issue_s;
  logic              last_s;
  logic              store_s;
  logic              accept_mem_s;
  logic              misalign_s;
  logic [DATA_W-1:0] load_word_s;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_r;
  assign misalign_s = op_misaligned(mem_op_i, addr_i[1:0]);
  assign misalign_o = misalign_r;
`else
  assign misalign_s = 1'b0;
  assign misalign_o = 1'b0;
`endif

  // rst gates the issue so a reset cycle never writes RAM.
  assign issue_s      = (state_r == ST_BUSY) && ram_grant_i && !rst;
  assign last_s       = (k_r == (op_bytes(op_r) - 3'd1));
  assign store_s      = op_is_store(op_r);
  assign accept_mem_s = (state_r == ST_IDLE) && valid_i &&
                        (op_bytes(mem_op_i) != 3'd0) && !misalign_s;

  assign stall_req_o = !rst && (accept_mem_s || (state_r != ST_IDLE));
  assign ram_addr_o  = issue_s ? (base_r + ADDR_W'(k_r)) : '0;
  assign ram_wr_o    = issue_s && store_s;
  assign ram_dout_o  = (issue_s && store_s) ? wdata_r[{k_r[1:0], 3'b000} +: 8] : 8'h00;

  // Assembled load word including the byte arriving this cycle.
  always_comb begin
    load_word_s = asm_r;
    if (issued_r) begin
      load_word_s[{lane_r, 3'b000} +: 8] = ram_din_i;
    end else begin
      load_word_s = asm_r;
    end
  end

  // FSM, byte capture and registered writeback bundle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      op_r      <= 4'd0;
      base_r    <= '0;
      wdata_r   <= '0;
      rd_addr_r <= 5'd0;
      rd_en_r   <= 1'b0;
      k_r       <= 3'd0;
      issued_r  <= 1'b0;
      lane_r    <= 2'd0;
      asm_r     <= '0;
      valid_o   <= 1'b0;
      rd_addr_o <= 5'd0;
      rd_en_o   <= 1'b0;
      rd_data_o <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_r <= 1'b0;
`endif
    end else begin
      valid_o  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_r <= 1'b0;
`endif
      // Byte lands one cycle after its address issued; gaps simply skip.
      issued_r <= issue_s && !store_s;
      lane_r   <= k_r[1:0];
      if (issued_r) asm_r <= load_word_s;
      case (state_r)
        ST_IDLE: begin
          if (valid_i) begin
            if (op_bytes(mem_op_i) == 3'd0) begin
              valid_o   <= 1'b1;
              rd_addr_o <= rd_addr_i;
              rd_en_o   <= rd_en_i;
              rd_data_o <= rd_data_i;
            end else if (misalign_s) begin
              valid_o   <= 1'b1;
              rd_addr_o <= rd_addr_i;
              rd_en_o   <= 1'b0;
              rd_data_o <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
              misalign_r <= 1'b1;
`endif
            end else begin
              op_r      <= mem_op_i;
              base_r    <= addr_i;
              wdata_r   <= wdata_i;
              rd_addr_r <= rd_addr_i;
              rd_en_r   <= rd_en_i;
              k_r       <= 3'd0;
              asm_r     <= '0;
              state_r   <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (issue_s) begin
            if (last_s) begin
              k_r <= 3'd0;
              if (store_s) begin
                state_r   <= ST_IDLE;
                valid_o   <= 1'b1;
                rd_addr_o <= rd_addr_r;
                rd_en_o   <= 1'b0;
                rd_data_o <= '0;
              end else begin
                state_r <= ST_DRAIN;
              end
            end else begin
              k_r <= k_r + 3'd1;
            end
          end
        end
        ST_DRAIN: begin
          rd_data_o <= load_ext(op_r, load_word_s);
          rd_addr_o <= rd_addr_r;
          rd_en_o   <= rd_en_r;
          valid_o   <= 1'b1;
          state_r   <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [3:0]  mem_op_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [4:0]  rd_addr_i;
  logic        rd_en_i;
  logic [31:0] rd_data_i;
  logic        ram_grant_i;
  logic [7:0]  ram_din_i;
  logic [31:0] ram_addr_o;
  logic        ram_wr_o;
  logic [7:0]  ram_dout_o;
  logic        stall_req_o;
  logic        valid_o;
  logic [4:0]  rd_addr_o;
  logic        rd_en_o;
  logic [31:0] rd_data_o;
  logic        misalign_o;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] mem [0:4095];

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .mem_op_i(mem_op_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rd_addr_i(rd_addr_i),
    .rd_en_i(rd_en_i), .rd_data_i(rd_data_i), .ram_grant_i(ram_grant_i),
    .ram_din_i(ram_din_i), .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o),
    .ram_dout_o(ram_dout_o), .stall_req_o(stall_req_o), .valid_o(valid_o),
    .rd_addr_o(rd_addr_o), .rd_en_o(rd_en_o), .rd_data_o(rd_data_o),
    .misalign_o(misalign_o)
  );

  // Byte RAM: synchronous write, read data one cycle after address.
  always @(posedge clk) begin
    if (ram_wr_o) mem[ram_addr_o[11:0]] <= ram_dout_o;
    ram_din_i <= mem[ram_addr_o[11:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input int n);
    cyc();
    valid_i = 1'b1; mem_op_i = op; addr_i = addr; wdata_i = data;
    rd_addr_i = 5'd7; rd_en_i = 1'b1; ram_grant_i = 1'b1;
    @(negedge clk);
    chk({tag, ".stall_c0"}, {31'd0, stall_req_o}, 32'd1);
    for (int k = 0; k < n; k++) begin
      cyc();
      valid_i = 1'b0;
      @(negedge clk);
      chk({tag, ".addr"}, ram_addr_o, addr + k);
      chk({tag, ".wr"}, {31'd0, ram_wr_o}, 32'd1);
      chk({tag, ".dout"}, {24'd0, ram_dout_o}, (data >> (8 * k)) & 32'h0000_00FF);
      chk({tag, ".stall"}, {31'd0, stall_req_o}, 32'd1);
    end
    cyc();
    @(negedge clk);
    chk({tag, ".valid"}, {31'd0, valid_o}, 32'd1);
    chk({tag, ".rd_en"}, {31'd0, rd_en_o}, 32'd0);
    chk({tag, ".stall_done"}, {31'd0, stall_req_o}, 32'd0);
  endtask

  task automatic do_load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input int n, input logic [31:0] exp);
    cyc();
    valid_i = 1'b1; mem_op_i = op; addr_i = addr; wdata_i = 32'h0;
    rd_addr_i = 5'd9; rd_en_i = 1'b1; ram_grant_i = 1'b1;
    @(negedge clk);
    chk({tag, ".stall_c0"}, {31'd0, stall_req_o}, 32'd1);
    for (int k = 0; k < n; k++) begin
      cyc();
      valid_i = 1'b0;
      @(negedge clk);
      chk({tag, ".addr"}, ram_addr_o, addr + k);
      chk({tag, ".wr"}, {31'd0, ram_wr_o}, 32'd0);
    end
    cyc();
    @(negedge clk);
    chk({tag, ".drain_stall"}, {31'd0, stall_req_o}, 32'd1);
    chk({tag, ".drain_valid"}, {31'd0, valid_o}, 32'd0);
    cyc();
    @(negedge clk);
    chk({tag, ".valid"}, {31'd0, valid_o}, 32'd1);
    chk({tag, ".data"}, rd_data_o, exp);
    chk({tag, ".rd_addr"}, {27'd0, rd_addr_o}, 32'd9);
    chk({tag, ".rd_en"}, {31'd0, rd_en_o}, 32'd1);
    chk({tag, ".stall_done"}, {31'd0, stall_req_o}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; mem_op_i = 4'd0; addr_i = 32'h0; wdata_i = 32'h0;
    rd_addr_i = 5'd0; rd_en_i = 1'b0; rd_data_i = 32'h0; ram_grant_i = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    chk("rst.valid", {31'd0, valid_o}, 32'd0);
    chk("rst.rd_data", rd_data_o, 32'd0);
    chk("rst.ram_addr", ram_addr_o, 32'd0);
    chk("rst.stall", {31'd0, stall_req_o}, 32'd0);
    chk("rst.misalign", {31'd0, misalign_o}, 32'd0);
    cyc();
    rst = 1'b0;

    // Non-memory op: bundle passes through with a one-cycle latency.
    cyc();
    valid_i = 1'b1; mem_op_i = 4'd0; rd_data_i = 32'h1234_5678; rd_addr_i = 5'd5; rd_en_i = 1'b1;
    @(negedge clk);
    chk("alu.stall_c0", {31'd0, stall_req_o}, 32'd0);
    cyc();
    valid_i = 1'b0;
    @(negedge clk);
    chk("alu.valid", {31'd0, valid_o}, 32'd1);
    chk("alu.data", rd_data_o, 32'h1234_5678);
    chk("alu.rd_addr", {27'd0, rd_addr_o}, 32'd5);
    chk("alu.rd_en", {31'd0, rd_en_o}, 32'd1);
    chk("alu.stall_c1", {31'd0, stall_req_o}, 32'd0);
    cyc();
    @(negedge clk);
    chk("alu.pulse", {31'd0, valid_o}, 32'd0);

    // Stores that also set up RAM contents for the loads.
    do_store("sw100", 4'd8, 32'h0000_0100, 32'hDEAD_BEEF, 4);
    chk("ram103", {24'd0, mem[12'h103]}, 32'h0000_00DE);
    do_store("sb200", 4'd6, 32'h0000_0200, 32'h0000_0080, 1);
    do_store("sw300", 4'd8, 32'h0000_0300, 32'h4433_2211, 4);
    do_store("sh304", 4'd7, 32'h0000_0304, 32'h0000_6655, 2);
    do_store("sh306", 4'd7, 32'h0000_0306, 32'h0000_8877, 2);
    do_store("sb401", 4'd6, 32'h0000_0401, 32'h0000_005A, 1);

    // Byte/half loads with sign and zero extension.
    do_load("lb200", 4'd1, 32'h0000_0200, 1, 32'hFFFF_FF80);
    do_load("lbu200", 4'd4, 32'h0000_0200, 1, 32'h0000_0080);
    do_load("lh306", 4'd2, 32'h0000_0306, 2, 32'hFFFF_8877);
    do_load("lhu306", 4'd5, 32'h0000_0306, 2, 32'h0000_8877);

    // LW 0x300 with a grant gap in cycle 2.
    cyc();
    valid_i = 1'b1; mem_op_i = 4'd3; addr_i = 32'h0000_0300; rd_addr_i = 5'd9; rd_en_i = 1'b1;
    ram_grant_i = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      cyc();
      valid_i = 1'b0;
      ram_grant_i = (c == 2) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (c == 2) begin
        chk("gap.addr_c2", ram_addr_o, 32'd0);
        chk("gap.wr_c2", {31'd0, ram_wr_o}, 32'd0);
      end
      if (c == 5) chk("gap.addr_c5", ram_addr_o, 32'h0000_0303);
      if (c <= 6) chk("gap.stall", {31'd0, stall_req_o}, 32'd1);
      if (c == 6) chk("gap.valid_c6", {31'd0, valid_o}, 32'd0);
      if (c == 7) begin
        chk("gap.valid_c7", {31'd0, valid_o}, 32'd1);
        chk("gap.data", rd_data_o, 32'h4433_2211);
        chk("gap.stall_c7", {31'd0, stall_req_o}, 32'd0);
      end
    end

    // Reset in cycle 2 of SW 0x400: only byte 0x400 lands.
    cyc();
    valid_i = 1'b1; mem_op_i = 4'd8; addr_i = 32'h0000_0400; wdata_i = 32'hA1B2_C3D4;
    ram_grant_i = 1'b1;
    cyc();
    valid_i = 1'b0;
    @(negedge clk);
    chk("rstmid.dout_c1", {24'd0, ram_dout_o}, 32'h0000_00D4);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid.wr_c2", {31'd0, ram_wr_o}, 32'd0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid.valid", {31'd0, valid_o}, 32'd0);
    chk("rstmid.stall", {31'd0, stall_req_o}, 32'd0);
    chk("rstmid.ram_addr", ram_addr_o, 32'd0);
    chk("rstmid.ram401", {24'd0, mem[12'h401]}, 32'h0000_005A);
    do_load("lb400", 4'd1, 32'h0000_0400, 1, 32'hFFFF_FFD4);
    do_load("lbu401", 4'd4, 32'h0000_0401, 1, 32'h0000_005A);

    // Misaligned LW 0x302.
`ifdef MEM_MISALIGN_TRAP_EN
    cyc();
    valid_i = 1'b1; mem_op_i = 4'd3; addr_i = 32'h0000_0302; rd_addr_i = 5'd9; rd_en_i = 1'b1;
    @(negedge clk);
    chk("mis.stall_c0", {31'd0, stall_req_o}, 32'd0);
    cyc();
    valid_i = 1'b0;
    @(negedge clk);
    chk("mis.valid", {31'd0, valid_o}, 32'd1);
    chk("mis.flag", {31'd0, misalign_o}, 32'd1);
    chk("mis.rd_en", {31'd0, rd_en_o}, 32'd0);
    chk("mis.ram_addr", ram_addr_o, 32'd0);
    cyc();
    @(negedge clk);
    chk("mis.flag_pulse", {31'd0, misalign_o}, 32'd0);
`else
    do_load("lw302", 4'd3, 32'h0000_0302, 4, 32'h6655_4433);
    chk("mis.flag_off", {31'd0, misalign_o}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM stage of the 5-stage RV32I core; consumes the EX result (op, effective address, store data, rd info) and performs the memory access over a byte-wide RAM port shared with instruction fetch.
- Multi-byte loads/stores are serialised one byte per cycle. The block raises a stall request to freeze upstream stages until the access completes.
- Produces the registered writeback bundle for the MEM/WB register.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, register data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- valid_i  in  1  EX bundle valid this cycle
- mem_op_i  in  4  0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW, others treated as 0
- addr_i  in  32  effective address
- wdata_i  in  32  store data
- rd_addr_i  in  5  destination register
- rd_en_i  in  1  destination write enable
- rd_data_i  in  32  ALU result (non-memory ops)
- ram_grant_i  in  1  RAM port granted to MEM this cycle
- ram_din_i  in  8  RAM read byte, valid one cycle after address issue
- ram_addr_o  out  32  RAM byte address
- ram_wr_o  out  1  RAM write strobe
- ram_dout_o  out  8  RAM write byte
- stall_req_o  out  1  freeze IF/ID/EX
- valid_o  out  1  writeback bundle valid (one-cycle pulse)
- rd_addr_o  out  5  writeback register
- rd_en_o  out  1  writeback enable
- rd_data_o  out  32  writeback data
- misalign_o  out  1  misaligned access flag (see Optional Feature)

Behaviour:
- Reset: rst is synchronous, active-high.
  - All outputs reset to 0. FSM resets to IDLE; byte counter and assembly register reset to 0.
  - Reset mid-access aborts the access. No further RAM writes occur, and bytes already written stay written.
- States: IDLE, BUSY, DRAIN.
- IDLE + valid_i with a non-memory op:
  - Register rd_addr_i/rd_en_i/rd_data_i.
  - valid_o=1 the next cycle. stall_req_o is never raised.
- IDLE + valid_i with a memory op (accept cycle 0):
  - Latch all inputs. stall_req_o=1 combinationally in cycle 0.
  - Next state BUSY. N = 1/2/4 bytes for B/H/W.
- BUSY:
  - Each cycle with ram_grant_i=1 issues byte k (k = 0..N-1): ram_addr_o = base+k (mod 2^32).
  - Store: ram_wr_o=1 and ram_dout_o = wdata[8k+7:8k] (little-endian).
  - Load: ram_wr_o=0.
  - A cycle with ram_grant_i=0 issues nothing: ram_wr_o=0, k holds, latency extends.
  - After byte N-1 issues: a store goes to IDLE and pulses valid_o with rd_en_o=0; a load goes to DRAIN.
- Load capture:
  - A registered "issued" flag captures ram_din_i into byte lane k one cycle after each issue. This is grant-gap safe.
- DRAIN:
  - Capture the last byte, then register rd_data_o.
  - LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend. LW takes all 32 bits.
  - valid_o=1 with rd_en_o = latched rd_en, then go to IDLE.
- Latency with continuous grant:
  - Load: valid_o in cycle N+2.
  - Store: store completion (valid_o) in cycle N+1.
  - stall_req_o is high from cycle 0 through the cycle before valid_o, and is low in the valid_o cycle.
- valid_i while not IDLE is ignored; upstream holds its bundle under stall.
- Idle RAM outputs: ram_addr_o=0, ram_wr_o=0, ram_dout_o=0.
- rd_addr 0 is passed unchanged; x0 suppression happens in the register file.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Enabled:
  - LH/LHU/SH with addr[0]≠0, and LW/SW with addr[1:0]≠0, perform no RAM access.
  - Such an op completes next cycle: valid_o=1, rd_en_o=0, misalign_o=1 for one cycle, no stall.
- Disabled:
  - Misaligned accesses execute byte-serially like aligned ones.
  - misalign_o is tied 0.

Test Plan:
- Non-memory op, rd_data_i=0x1234_5678, rd_addr_i=5, rd_en_i=1 -> next cycle valid_o=1, rd_data_o=0x12345678, rd_addr_o=5; stall_req_o never 1.
- SW addr=0x100, wdata=0xDEADBEEF, grant=1 -> cycles 1–4 write 0xEF,0xBE,0xAD,0xDE to 0x100–0x103; valid_o in cycle 5 with rd_en_o=0; stall_req_o high cycles 0–4.
- RAM holds 0x80 at 0x200: LB 0x200 gives rd_data_o=0xFFFFFF80 in cycle 3. LBU gives 0x00000080.
- LW 0x300 (RAM 11 22 33 44) with ram_grant_i=0 in cycle 2 -> no issue in cycle 2; rd_data_o=0x44332211 in cycle 7; stall held through cycle 6.
- rst asserted in cycle 2 of SW 0x400 -> only byte 0x400 is written; next cycle all outputs 0 and state IDLE; a following LB is accepted normally.
- With MEM_MISALIGN_TRAP_EN, LW 0x302 -> no RAM activity, next cycle valid_o=1, misalign_o=1, rd_en_o=0. Without it -> reads 0x302–0x305 normally.
